// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// default operand width and the per-state strobe decode.
package mult_pkg;

    localparam int unsigned MULT_WIDTH_DEF = 4;
    localparam int unsigned ST_W           = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_ADD  = 3'd3,
        ST_SHB  = 3'd4,
        ST_SHP  = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    typedef struct packed {
        logic clr;
        logic ld;
        logic ldp;
        logic shb;
        logic shp;
        logic busy;
        logic done;
    } strobes_t;

    // One-hot strobe decode; unknown encodings decode to all-zero.
    function automatic strobes_t decode_state(input state_e s);
        strobes_t o;
        o = '0;
        case (s)
            ST_CLR:  begin o.clr  = 1'b1; o.busy = 1'b1; end
            ST_LOAD: begin o.ld   = 1'b1; o.busy = 1'b1; end
            ST_ADD:  begin o.ldp  = 1'b1; o.busy = 1'b1; end
            ST_SHB:  begin o.shb  = 1'b1; o.busy = 1'b1; end
            ST_SHP:  begin o.shp  = 1'b1; o.busy = 1'b1; end
            ST_DONE: begin o.done = 1'b1; o.busy = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier sequencer: synchronous clear,
// increment enable, saturates at WIDTH-1 and flags the last iteration.
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter  int unsigned WIDTH = MULT_WIDTH_DEF,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Start/busy/done sequencer for the shift-and-add multiplier datapath.
// Define ZERO_SKIP_EN to gate the ADD-state load strobe with mbit.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter  int unsigned WIDTH = MULT_WIDTH_DEF,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mbit,
    output logic             clr,
    output logic             ld,
    output logic             ldp,
    output logic             shb,
    output logic             shp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    state_e   cs_q, ns_d;
    strobes_t out_q, out_d;
    logic     cnt_clr, cnt_inc, iter_last;

    assign cnt_clr = abort || (cs_q == ST_CLR);
    assign cnt_inc = (cs_q == ST_SHP);

    mult_iter_cnt #(.WIDTH(WIDTH)) u_iter_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (iter),
        .term_o (iter_last)
    );

    always_comb begin
        ns_d = ST_IDLE;
        if (!abort) begin
            case (cs_q)
                ST_IDLE: ns_d = start ? ST_CLR : ST_IDLE;
                ST_CLR:  ns_d = ST_LOAD;
                ST_LOAD: ns_d = ST_ADD;
                ST_ADD:  ns_d = iter_last ? ST_DONE : ST_SHB;
                ST_SHB:  ns_d = ST_SHP;
                ST_SHP:  ns_d = ST_ADD;
                ST_DONE: ns_d = ST_IDLE;
                default: ns_d = ST_IDLE;
            endcase
        end
        // Outputs are registered from the next state so they stay Moore and glitch-free.
        out_d = decode_state(ns_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q  <= ST_IDLE;
            out_q <= '0;
        end else begin
            cs_q  <= ns_d;
            out_q <= out_d;
        end
    end

    assign clr  = out_q.clr;
    assign ld   = out_q.ld;
    assign shb  = out_q.shb;
    assign shp  = out_q.shp;
    assign busy = out_q.busy;
    assign done = out_q.done;

`ifdef ZERO_SKIP_EN
    assign ldp = out_q.ldp & mbit;
`else
    logic unused_mbit;
    assign unused_mbit = mbit;
    assign ldp = out_q.ldp;
`endif

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl: a per-cycle vector table for the
// WIDTH=4 run, then hand sequences for held start, abort, reset and WIDTH=8.
module tb_shift_add_mult_ctrl;

    localparam bit ZS =
`ifdef ZERO_SKIP_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n, start, abort, mbit;
    logic       clr, ld, ldp, shb, shp, busy, done;
    logic [1:0] iter;
    logic       start8, abort8, mbit8;
    logic       clr8, ld8, ldp8, shb8, shp8, busy8, done8;
    logic [2:0] iter8;
    logic [6:0] o4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign o4 = {clr, ld, ldp, shb, shp, busy, done};

    shift_add_mult_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mbit(mbit),
        .clr(clr), .ld(ld), .ldp(ldp), .shb(shb), .shp(shp),
        .busy(busy), .done(done), .iter(iter)
    );

    shift_add_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .abort(abort8), .mbit(mbit8),
        .clr(clr8), .ld(ld8), .ldp(ldp8), .shb(shb8), .shp(shp8),
        .busy(busy8), .done(done8), .iter(iter8)
    );

    typedef struct {
        logic       start;
        logic       mbit;
        logic [6:0] exp;
        logic [1:0] it;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input logic s, input logic m, input logic [6:0] e, input logic [1:0] it);
        vec_t v;
        v.start = s; v.mbit = m; v.exp = e; v.it = it;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        int n, nd, first, second, nl, nsb, nsp;
        logic busy14, dseen, iterok;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; mbit = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; mbit8 = 1'b1;

        // bits: {clr, ld, ldp, shb, shp, busy, done}
        vt[0]  = mk(1'b1, 1'b0, 7'b1000010, 2'd0);
        vt[1]  = mk(1'b0, 1'b0, 7'b0100010, 2'd0);
        vt[2]  = mk(1'b0, 1'b1, 7'b0010010, 2'd0);
        vt[3]  = mk(1'b0, 1'b0, 7'b0001010, 2'd0);
        vt[4]  = mk(1'b0, 1'b0, 7'b0000110, 2'd0);
        vt[5]  = mk(1'b0, 1'b0, {2'b00, ~ZS, 4'b0010}, 2'd1);
        vt[6]  = mk(1'b0, 1'b0, 7'b0001010, 2'd1);
        vt[7]  = mk(1'b0, 1'b0, 7'b0000110, 2'd1);
        vt[8]  = mk(1'b0, 1'b1, 7'b0010010, 2'd2);
        vt[9]  = mk(1'b0, 1'b0, 7'b0001010, 2'd2);
        vt[10] = mk(1'b0, 1'b0, 7'b0000110, 2'd2);
        vt[11] = mk(1'b0, 1'b1, 7'b0010010, 2'd3);
        vt[12] = mk(1'b0, 1'b0, 7'b0000011, 2'd3);
        vt[13] = mk(1'b0, 1'b0, 7'b0000000, 2'd3);

        step();
        step();
        chk("reset_outputs", {25'd0, o4}, 32'd0);
        chk("reset_iter", {30'd0, iter}, 32'd0);
        chk("reset_outputs_w8", {25'd0, clr8, ld8, ldp8, shb8, shp8, busy8, done8}, 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            start = vt[i].start;
            mbit  = vt[i].mbit;
            step();
            chk($sformatf("vec%0d_strobes", i), {25'd0, o4}, {25'd0, vt[i].exp});
            chk($sformatf("vec%0d_iter", i), {30'd0, iter}, {30'd0, vt[i].it});
        end
        mbit = 1'b1;

        // start held high through consecutive runs
        start = 1'b1; nd = 0; first = 0; second = 0; busy14 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 14) busy14 = busy;
            if (done) begin
                nd++;
                if (nd == 1) first = c;
                else if (nd == 2) second = c;
            end
        end
        chk("held_done_count", nd, 2);
        chk("held_first_done", first, 13);
        chk("held_second_done", second, 27);
        chk("held_idle_gap_busy", {31'd0, busy14}, 32'd0);
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("held_abort_idle", {25'd0, o4}, 32'd0);

        // abort in the third SHB cycle
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) step();
        chk("abort_pre_shb", {31'd0, shb}, 32'd1);
        chk("abort_pre_iter", {30'd0, iter}, 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_outputs", {25'd0, o4}, 32'd0);
        chk("abort_iter", {30'd0, iter}, 32'd0);
        dseen = 1'b0;
        repeat (5) begin
            step();
            if (done) dseen = 1'b1;
        end
        chk("abort_no_done", {31'd0, dseen}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n < 30) begin
            step();
            n++;
        end
        chk("rerun_latency", n, 13);
        chk("rerun_iter", {30'd0, iter}, 32'd3);
        step();
        chk("rerun_idle", {25'd0, o4}, 32'd0);
        chk("iter_holds_idle", {30'd0, iter}, 32'd3);

        // abort outranks start in IDLE and clears the held iter
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_prio_outputs", {25'd0, o4}, 32'd0);
        chk("abort_prio_iter", {30'd0, iter}, 32'd0);

        // asynchronous reset during the second ADD
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("rst_pre_ldp", {31'd0, ldp}, 32'd1);
        chk("rst_pre_iter", {30'd0, iter}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", {25'd0, o4}, 32'd0);
        chk("rst_async_iter", {30'd0, iter}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // WIDTH=8 full run
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 1; nl = 0; nsb = 0; nsp = 0; iterok = 1'b1;
        while (!done8 && n < 40) begin
            if (ldp8) begin
                if (int'(iter8) != nl) iterok = 1'b0;
                nl++;
            end
            if (shb8) nsb++;
            if (shp8) nsp++;
            step();
            n++;
        end
        chk("w8_done_cycle", n, 25);
        chk("w8_ldp_count", nl, 8);
        chk("w8_shb_count", nsb, 7);
        chk("w8_shp_count", nsp, 7);
        chk("w8_iter_steps", {31'd0, iterok}, 32'd1);
        chk("w8_final_iter", {29'd0, iter8}, 32'd7);
        step();
        chk("w8_idle_busy", {31'd0, busy8}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Parametrised sequencer for the shift-and-add multiplier datapath; successor to the fixed 4-bit free-running controller.
- Adds WIDTH generalisation, a start/busy/done handshake, synchronous abort and an iteration counter.
- Drives the same five datapath strobes (clr, ld, ldp, shb, shp).
- Sits between the top-level control/test logic and the multiplicand/multiplier/product register datapath.

Parameters:
WIDTH, 4, operand width in bits; number of add iterations; legal range 2..32.
CNT_W, $clog2(WIDTH), width of the iteration counter output (derived localparam, not overridable).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request a multiply; sampled only in IDLE.
abort  input  1  synchronous cancel; returns to IDLE next edge.
mbit  input  1  current multiplier LSB from datapath; used only with ZERO_SKIP_EN.
clr  output  1  clear product register.
ld  output  1  load multiplicand and multiplier registers.
ldp  output  1  load adder result into product upper half.
shb  output  1  shift multiplier register right one bit.
shp  output  1  shift product register right one bit.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse, product valid.
iter  output  CNT_W  index of the bit being processed, 0..WIDTH-1.

Behaviour:
Reset: cs=IDLE, iter=0; all outputs 0.
States: IDLE, CLR, LOAD, ADD, SHB, SHP, DONE.
- Moore outputs: each strobe is decoded from cs only, one-hot per state.
  - CLR: clr=1. LOAD: ld=1. ADD: ldp=1. SHB: shb=1. SHP: shp=1. DONE: done=1.
  - busy=1 in all states other than IDLE.
Transitions:
- IDLE: start=1 -> CLR; else stay in IDLE.
- CLR -> LOAD; iter cleared to 0.
- LOAD -> ADD.
- ADD: iter==WIDTH-1 -> DONE; else -> SHB.
- SHB -> SHP.
- SHP -> ADD; iter increments.
- DONE -> IDLE unconditionally (no terminal hold state, unlike the previous generation).
Latency:
- start sampled at edge E0; done=1 during cycle 3*WIDTH+1 after E0 (13 for WIDTH=4).
- Per run: exactly WIDTH ldp pulses, and WIDTH-1 pulses each of shb and shp.
Rules:
- start while busy: ignored, no queuing.
- start in the DONE cycle: ignored; may be reasserted in IDLE on the following cycle.
- abort has priority over every transition, including start in IDLE. It forces IDLE at the next edge and clears iter; done is not pulsed.
- reset_n low mid-run: immediate IDLE, all outputs 0.
- iter holds its value in IDLE after a completed run until the next CLR; it saturates logically at WIDTH-1 (never wraps).
- Illegal cs encoding: ns=IDLE, outputs 0.

Optional Feature:
Macro ZERO_SKIP_EN.
- Defined: in ADD, ldp=mbit, so the add is suppressed when the multiplier bit is 0. State sequence and latency are unchanged.
- Undefined: mbit is ignored and ldp=1 in every ADD cycle (product of an unconditional add is handled in the datapath).

Decomposition:
- Shared package mult_pkg: state encoding constants (ST_IDLE=0 .. ST_DONE=6, 3-bit state width) and the WIDTH default. The datapath and bench reuse these.
- Sub-module mult_iter_cnt: CNT_W-bit counter with synchronous clear (CLR or abort), increment enable (SHP) and terminal flag iter==WIDTH-1. It feeds the ADD branch decision.

Test Plan:
- WIDTH=4, reset_n released, start pulse -> strobes clr,ld,ldp,shb,shp,ldp,shb,shp,ldp,shb,shp,ldp, done=1 in cycle 13; busy high in cycles 1..13.
- WIDTH=8, start -> exactly 8 ldp, 7 shb and 7 shp pulses; done in cycle 25; iter steps 0..7.
- Start held high through a run -> second run begins only after IDLE is re-entered; no extra done pulse.
- Abort in the third SHB cycle -> IDLE next edge, busy=0, done never asserted, iter=0; a new start then runs a full 13-cycle sequence.
- reset_n low during ADD -> all outputs 0 immediately, asynchronous to clk.
- ZERO_SKIP_EN, WIDTH=4, mbit pattern 1,0,1,1 across the ADD cycles -> ldp = 1,0,1,1; timing identical to the first scenario.
